sd_rx_burst_filler: RTL and testbench

//  Packs narrow SD receive data (IN_W bits per strobe) into 32-bit words and

---
 rtl/sd_rx_burst_filler_if.sv | 27 ++
 rtl/sd_rx_burst_filler.sv | 181 ++++++++++++++++++
 tb/tb_sd_rx_burst_filler.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_rx_burst_filler_if.sv
// rtl/sd_rx_burst_filler_if.sv - Wishbone master bus bundle for the SD receive burst filler
interface sd_rx_burst_filler_if #(
   parameter int ADR_W = 32
);
   logic [ADR_W-1:0] m_wb_adr_o;
   logic [31:0]      m_wb_dat_o;
   logic [3:0]       m_wb_sel_o;
   logic             m_wb_we_o;
   logic             m_wb_cyc_o;
   logic             m_wb_stb_o;
   logic [2:0]       m_wb_cti_o;
   logic [1:0]       m_wb_bte_o;
   logic             m_wb_ack_i;
   logic             m_wb_err_i;

   modport master (
      output m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_cyc_o,
             m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
      input  m_wb_ack_i, m_wb_err_i
   );

   modport slave (
      input  m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_cyc_o,
             m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
      output m_wb_ack_i, m_wb_err_i
   );
endinterface

// File: rtl/sd_rx_burst_filler.sv
// rtl/sd_rx_burst_filler.sv - packs SD receive data into words, FIFOs them, drains via Wishbone bursts
module sd_rx_burst_filler #(
   parameter int IN_W       = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int BURST_LEN  = 4,
   parameter int ADR_W      = 32,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [ADR_W-1:0]     adr,
   input  logic [CNT_W-1:0]     blk_words,
   input  logic [IN_W-1:0]      in_dat,
   input  logic                 in_wr,
   output logic                 full,
   output logic                 overflow,
   output logic                 done,
   output logic                 error,
   sd_rx_burst_filler_if.master wb
);
   localparam int BEATS = 32 / IN_W;
   localparam int PKW   = $clog2(BEATS);
   localparam int AW    = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_BURST, S_DONE, S_ERR} state_t;

   state_t            state;
   logic [31-IN_W:0]  pack;
   logic [31:0]       shifted;
   logic [31:0]       push_word;
   logic [PKW-1:0]    pk_cnt;
   logic              push_vld;
   logic [31:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]     wptr, rptr;
   logic [AW:0]       fcnt;
   logic              push_ok, pop;
   logic [CNT_W-1:0]  word_cnt, rem, beats_left, burst_n;
   logic              bus;
   logic [ADR_W-1:0]  adr_q;
   logic [2:0]        cti_q;

   assign shifted = {pack, in_dat};
   assign full    = (fcnt == (AW+1)'(FIFO_DEPTH));
   assign pop     = en && (state == S_BURST) && wb.m_wb_ack_i && !wb.m_wb_err_i;
   // A full FIFO still accepts a word when the same cycle pops one.
   assign push_ok = en && push_vld && (!full || pop);
   assign burst_n = (rem < CNT_W'(BURST_LEN)) ? rem : CNT_W'(BURST_LEN);

   assign wb.m_wb_adr_o = adr_q;
   assign wb.m_wb_dat_o = bus ? mem[rptr] : 32'h0;
   assign wb.m_wb_sel_o = 4'hF;
   assign wb.m_wb_we_o  = bus;
   assign wb.m_wb_cyc_o = bus;
   assign wb.m_wb_stb_o = bus;
   assign wb.m_wb_cti_o = cti_q;
   assign wb.m_wb_bte_o = 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pack      <= '0;
         push_word <= '0;
         pk_cnt    <= '0;
         push_vld  <= 1'b0;
      end else if (!en) begin
         pack     <= '0;
         pk_cnt   <= '0;
         push_vld <= 1'b0;
      end else begin
         push_vld <= 1'b0;
         if (in_wr) begin
            pack <= shifted[31-IN_W:0];
            if (pk_cnt == PKW'(BEATS-1)) begin
               pk_cnt    <= '0;
               push_vld  <= 1'b1;
               push_word <= shifted;
            end else begin
               pk_cnt <= pk_cnt + PKW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= push_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         fcnt <= '0;
      end else if (!en) begin
         wptr <= '0;
         rptr <= '0;
         fcnt <= '0;
      end else begin
         if (push_ok) wptr <= wptr + AW'(1);
         if (pop)     rptr <= rptr + AW'(1);
         if (push_ok && !pop)      fcnt <= fcnt + (AW+1)'(1);
         else if (pop && !push_ok) fcnt <= fcnt - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         word_cnt   <= '0;
         rem        <= '0;
         beats_left <= '0;
         bus        <= 1'b0;
         adr_q      <= '0;
         cti_q      <= 3'b000;
         done       <= 1'b0;
         error      <= 1'b0;
         overflow   <= 1'b0;
      end else if (!en) begin
         state      <= S_IDLE;
         word_cnt   <= '0;
         rem        <= '0;
         beats_left <= '0;
         bus        <= 1'b0;
         cti_q      <= 3'b000;
         done       <= 1'b0;
         error      <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (push_vld && full && !pop) overflow <= 1'b1;
         case (state)
            S_IDLE: begin
               word_cnt <= '0;
               rem      <= blk_words;
               state    <= S_LOAD;
            end
            S_LOAD: begin
               if (rem == '0) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (CNT_W'(fcnt) >= burst_n) begin
                  bus        <= 1'b1;
                  adr_q      <= adr + ADR_W'({word_cnt, 2'b00});
                  cti_q      <= (burst_n == CNT_W'(1)) ? 3'b000 : 3'b010;
                  beats_left <= burst_n;
                  state      <= S_BURST;
               end
            end
            S_BURST: begin
               if (wb.m_wb_err_i) begin
                  bus   <= 1'b0;
                  cti_q <= 3'b000;
                  error <= 1'b1;
                  state <= S_ERR;
               end else if (wb.m_wb_ack_i) begin
                  word_cnt   <= word_cnt + CNT_W'(1);
                  rem        <= rem - CNT_W'(1);
                  beats_left <= beats_left - CNT_W'(1);
                  if (beats_left == CNT_W'(1)) begin
                     bus   <= 1'b0;
                     cti_q <= 3'b000;
                     if (rem == CNT_W'(1)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                     end else begin
                        state <= S_WAIT;
                     end
                  end else begin
                     adr_q <= adr_q + ADR_W'(4);
                     cti_q <= (beats_left == CNT_W'(2)) ? 3'b111 : 3'b010;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sd_rx_burst_filler.sv
// tb/tb_sd_rx_burst_filler.sv - scoreboard bench for sd_rx_burst_filler with a randomized Wishbone slave
module tb_sd_rx_burst_filler;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [31:0] adr = '0;
   logic [15:0] blk_words = '0;
   logic [3:0]  in_dat = '0;
   logic        in_wr = 1'b0;
   logic        full, overflow, done, error;
   logic        ack = 1'b0, err = 1'b0;

   sd_rx_burst_filler_if #(.ADR_W(32)) wb ();
   assign wb.m_wb_ack_i = ack;
   assign wb.m_wb_err_i = err;

   sd_rx_burst_filler #(.IN_W(4), .FIFO_DEPTH(16), .BURST_LEN(4), .ADR_W(32), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .adr(adr), .blk_words(blk_words),
      .in_dat(in_dat), .in_wr(in_wr), .full(full), .overflow(overflow),
      .done(done), .error(error), .wb(wb)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [2:0]  cti;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] words[$];
   int          n_tests = 0, n_fail = 0;
   int          ack_delay = 0, err_at = -1;
   int          beats_seen = 0, wait_cnt = 0;
   bit          stall_prev = 1'b0;
   logic [66:0] prev_v;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Slave model and monitor: decides ack/err for the coming edge, then scores the accepted beat.
   always @(negedge clk) begin
      logic [66:0] cur;
      beat_t       e;
      ack = 1'b0;
      err = 1'b0;
      if (!en) begin
         beats_seen = 0;
         wait_cnt   = 0;
         stall_prev = 1'b0;
      end else if (wb.m_wb_cyc_o && wb.m_wb_stb_o) begin
         cur = {wb.m_wb_adr_o, wb.m_wb_dat_o, wb.m_wb_cti_o};
         if (stall_prev) check("hold_while_stalled", cur, prev_v);
         if (ack_delay >= 0 && wait_cnt >= ack_delay) begin
            wait_cnt = 0;
            ack = 1'b1;
            if (beats_seen == err_at) begin
               err = 1'b1;
            end else if (exp_q.size() == 0) begin
               check("unexpected_beat", {wb.m_wb_adr_o, wb.m_wb_dat_o}, 64'h0);
            end else begin
               e = exp_q.pop_front();
               check("beat", {wb.m_wb_adr_o, wb.m_wb_dat_o, wb.m_wb_cti_o, wb.m_wb_sel_o,
                              wb.m_wb_we_o, wb.m_wb_bte_o},
                     {e.adr, e.dat, e.cti, 4'hF, 1'b1, 2'b00});
            end
            beats_seen++;
            stall_prev = 1'b0;
         end else begin
            wait_cnt++;
            stall_prev = 1'b1;
            prev_v = cur;
         end
      end else begin
         wait_cnt   = 0;
         stall_prev = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: words split into bursts of min(4, remaining), linear addresses.
   task automatic build(input int blk, input logic [31:0] base, input bit counting);
      int i = 0;
      int left = blk;
      words.delete();
      for (int w = 0; w < blk; w++) begin
         logic [31:0] v = '0;
         if (counting) for (int j = 0; j < 8; j++) v = (v << 4) | 32'((8 * w + j) % 16);
         else v = $urandom;
         words.push_back(v);
      end
      while (left > 0) begin
         int n = (left < 4) ? left : 4;
         for (int k = 0; k < n; k++) begin
            beat_t b;
            b.adr = base + 32'(4 * i);
            b.dat = words[i];
            b.cti = (n == 1) ? 3'b000 : ((k == n - 1) ? 3'b111 : 3'b010);
            exp_q.push_back(b);
            i++;
         end
         left -= n;
      end
   endtask

   task automatic start(input logic [31:0] base, input int blk);
      en = 1'b0;
      step();
      step();
      adr = base;
      blk_words = 16'(blk);
      en = 1'b1;
      step();
   endtask

   task automatic feed(input int first, input int cnt, input bit gate, input int gap_max);
      for (int i = first; i < first + cnt; i++) begin
         if (gate) begin
            int c = 0;
            while (full && c < 1000) begin step(); c++; end
            if (full) check("feed_full_timeout", 1, 0);
         end
         for (int j = 0; j < 8; j++) begin
            int g = $urandom_range(gap_max, 0);
            for (int k = 0; k < g; k++) step();
            in_dat = words[i][31 - 4 * j -: 4];
            in_wr = 1'b1;
            step();
            in_wr = 1'b0;
         end
      end
   endtask

   task automatic finish_txn(input string name);
      int c = 0;
      while (!done && c < 3000) begin step(); c++; end
      check({name, "_done"}, done, 1);
      step();
      check({name, "_bus_idle"}, wb.m_wb_cyc_o, 0);
      check({name, "_all_beats"}, exp_q.size(), 0);
      check({name, "_no_error"}, {error, overflow}, 0);
      exp_q.delete();
   endtask

   initial begin
      int c;
      bit seen;
      step();
      step();
      check("reset_bus", {wb.m_wb_cyc_o, wb.m_wb_stb_o, wb.m_wb_we_o, wb.m_wb_cti_o}, 0);
      check("reset_adr_dat", {wb.m_wb_adr_o, wb.m_wb_dat_o}, 0);
      check("reset_flags", {full, overflow, done, error}, 0);
      rst_n = 1'b1;
      step();

      ack_delay = 0;
      build(8, 32'h1000, 1'b1);
      start(32'h1000, 8);
      feed(0, 8, 1'b1, 0);
      finish_txn("t1_blk8");

      build(6, 32'h1000, 1'b1);
      start(32'h1000, 6);
      feed(0, 6, 1'b1, 0);
      finish_txn("t2_blk6");

      ack_delay = 3;
      build(8, 32'h0800, 1'b0);
      start(32'h0800, 8);
      feed(0, 8, 1'b1, 1);
      finish_txn("t3_slow_ack");

      ack_delay = 0;
      build(0, 32'h0, 1'b0);
      start(32'h0, 0);
      finish_txn("blk0");

      // Error on the second beat, asserted together with ack.
      err_at = 1;
      build(8, 32'h2000, 1'b0);
      start(32'h2000, 8);
      feed(0, 8, 1'b1, 0);
      c = 0;
      while (!error && c < 500) begin step(); c++; end
      check("t4_error", error, 1);
      check("t4_bus_idle", wb.m_wb_cyc_o, 0);
      check("t4_one_beat", exp_q.size(), 7);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin step(); if (wb.m_wb_cyc_o) seen = 1'b1; end
      check("t4_no_more_cycles", seen, 0);
      err_at = -1;
      exp_q.delete();
      en = 1'b0;
      step();
      step();
      check("t4_error_cleared", error, 0);
      build(8, 32'h2000, 1'b0);
      start(32'h2000, 8);
      feed(0, 8, 1'b1, 0);
      finish_txn("t4_restart");

      // Abort while a burst is stalled.
      ack_delay = -1;
      build(12, 32'h3000, 1'b0);
      start(32'h3000, 12);
      feed(0, 6, 1'b1, 0);
      c = 0;
      while (!wb.m_wb_cyc_o && c < 100) begin step(); c++; end
      check("t5_in_burst", wb.m_wb_cyc_o, 1);
      en = 1'b0;
      step();
      step();
      check("t5_abort", {wb.m_wb_cyc_o, wb.m_wb_stb_o, wb.m_wb_we_o, full}, 0);
      exp_q.delete();
      ack_delay = 0;
      build(8, 32'h3000, 1'b0);
      start(32'h3000, 8);
      feed(0, 8, 1'b1, 0);
      finish_txn("t5_restart");

      // Overflow: seventeen words into a sixteen-deep FIFO with the slave stalled.
      ack_delay = -1;
      build(16, 32'h4000, 1'b0);
      words.push_back($urandom);
      start(32'h4000, 16);
      feed(0, 17, 1'b0, 0);
      step();
      step();
      check("t6_full", full, 1);
      check("t6_overflow", overflow, 1);
      ack_delay = 0;
      c = 0;
      while (!done && c < 1000) begin step(); c++; end
      check("t6_done", done, 1);
      check("t6_all_beats", exp_q.size(), 0);
      check("t6_overflow_sticky", overflow, 1);
      exp_q.delete();

      for (int t = 0; t < 8; t++) begin
         int blk = $urandom_range(24, 1);
         logic [31:0] base = {$urandom_range(32'h3FFFFFFF, 0), 2'b00};
         ack_delay = $urandom_range(2, 0);
         build(blk, base, 1'b0);
         start(base, blk);
         feed(0, blk, 1'b1, 2);
         finish_txn("random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
